// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 serial receiver. Bit timing comes from a shared baud tick running at OS
//   ticks per bit. The start bit is confirmed half a bit after its falling edge.
//   Each data bit and the stop bit are then sampled one full bit period apart.
//   Every one of those samples therefore lands mid-bit.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_IDLE  | line idle; counters cleared; waiting for rx_s low
//   S_START | start edge seen; counting to mid-bit to confirm the start bit
//   S_DATA  | sampling 8 data bits, LSB first, one per OS ticks
//   S_STOP  | sampling the stop bit; done on high, frame error on low
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   baud_tick   one-clk pulse, OS pulses per bit period
//   rx          serial line, idle high, asynchronous to clk
//   o_rx_data   last correctly received byte
//   o_rx_done   one-clk pulse: o_rx_data holds a new byte
//   o_rx_busy   high from detected start edge until the stop bit is sampled
//   o_frame_err one-clk pulse: stop bit sampled low
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int OS  = 8,
  parameter int MID = OS / 2 - 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_rx_busy,
  output logic       o_frame_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [3:0] C_MID  = 4'(MID);
  localparam logic [3:0] C_LAST = 4'(OS - 1);

  logic       r_rx_meta;
  logic       r_rx_s;
  state_t     r_state;
  logic [3:0] r_b_cnt;
  logic [2:0] r_d_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_done;
  logic       r_err;

  state_t     w_state_nxt;
  logic [3:0] w_b_cnt_nxt;
  logic [2:0] w_d_cnt_nxt;
  logic [7:0] w_shift_nxt;
  logic [7:0] w_data_nxt;
  logic       w_done_nxt;
  logic       w_err_nxt;

  // The synchroniser resets to 1 (idle line) so that coming out of reset
  // cannot look like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_b_cnt <= '0;
      r_d_cnt <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_b_cnt <= w_b_cnt_nxt;
      r_d_cnt <= w_d_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_b_cnt_nxt = r_b_cnt;
    w_d_cnt_nxt = r_d_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_b_cnt_nxt = '0;
        w_d_cnt_nxt = '0;
        // Level detect, not edge detect. A line held low (break) restarts
        // a frame as soon as the previous one ends.
        if (!r_rx_s) begin
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        if (baud_tick) begin
          if (r_b_cnt == C_MID) begin
            w_b_cnt_nxt = '0;
            w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_b_cnt_nxt = r_b_cnt + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (r_b_cnt == C_LAST) begin
            w_shift_nxt = {r_rx_s, r_shift[7:1]};
            w_b_cnt_nxt = '0;
            w_d_cnt_nxt = r_d_cnt + 3'd1;
            if (r_d_cnt == 3'd7) begin
              w_state_nxt = S_STOP;
            end
          end else begin
            w_b_cnt_nxt = r_b_cnt + 4'd1;
          end
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          if (r_b_cnt == C_LAST) begin
            // Back to idle mid-stop-bit so that a start bit directly after
            // the stop bit is still caught on its edge.
            w_b_cnt_nxt = '0;
            w_state_nxt = S_IDLE;
            if (r_rx_s) begin
              w_data_nxt = r_shift;
              w_done_nxt = 1'b1;
            end else begin
              w_err_nxt  = 1'b1;
            end
          end else begin
            w_b_cnt_nxt = r_b_cnt + 4'd1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_rx_data   = r_data;
  assign o_rx_done   = r_done;
  assign o_frame_err = r_err;
  assign o_rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx. A tick generator provides one baud tick every
//   10 clk, or a tick on every clk when tick_always is set. Frames are
//   serialised in step with those ticks, OS ticks per bit. A monitor logs
//   received bytes, counts done/error pulses and busy cycles, and flags any
//   overlap or back-to-back done/error pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS = 8;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_rx_busy;
  logic       o_frame_err;

  logic       tick_always;
  int         tcnt;

  int         n_chk;
  int         n_fail;

  int         n_done;
  int         n_err;
  int         busy_cyc;
  int         viol;
  logic       prev_done;
  logic       prev_err;
  logic [7:0] rx_log[$];

  uart_rx #(.OS(OS)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .o_rx_data   (o_rx_data),
    .o_rx_done   (o_rx_done),
    .o_rx_busy   (o_rx_busy),
    .o_frame_err (o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    tcnt      = 0;
  end

  always @(posedge clk) begin
    if (tick_always) begin
      baud_tick <= 1'b1;
    end else begin
      tcnt      <= (tcnt == 9) ? 0 : tcnt + 1;
      baud_tick <= (tcnt == 9);
    end
  end

  initial begin
    n_done    = 0;
    n_err     = 0;
    busy_cyc  = 0;
    viol      = 0;
    prev_done = 1'b0;
    prev_err  = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (o_rx_done) begin
        n_done++;
        rx_log.push_back(o_rx_data);
      end
      if (o_frame_err) n_err++;
      if (o_rx_busy) busy_cyc++;
      if ((o_rx_done && o_frame_err) || (o_rx_done && prev_err) ||
          (o_frame_err && prev_done)) viol++;
      prev_done = o_rx_done;
      prev_err  = o_frame_err;
    end else begin
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns at the posedge where a baud tick was seen, n times.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      do begin
        @(posedge clk);
        g++;
      end while (!baud_tick && g < 64);
    end
  endtask

  task automatic send_bit(input logic b);
    #1 rx = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
  endtask

  // Stop bit held low until the receiver reports the error, then released.
  task automatic send_bad_stop(input logic [7:0] d);
    int e0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    e0 = n_err;
    #1 rx = 1'b0;
    for (int g = 0; g < 300 && n_err == e0; g++) @(negedge clk);
    rx = 1'b1;
    wait_ticks(2 * OS);
  endtask

  initial begin
    int d0, e0, b0, base;
    n_chk       = 0;
    n_fail      = 0;
    tick_always = 1'b0;
    rst         = 1'b1;
    rx          = 1'b1;

    // Watchdog runs alongside everything else.
    fork
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_data", o_rx_data, 8'h00);
    chk("rst_done", o_rx_done, 1'b0);
    chk("rst_busy", o_rx_busy, 1'b0);
    chk("rst_err",  o_frame_err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) @(posedge clk);

    // Single frame 0xA5
    d0 = n_done; e0 = n_err; b0 = busy_cyc;
    send_frame(8'hA5);
    wait_ticks(2 * OS);
    chk("a5_done_cnt", n_done - d0, 1);
    chk("a5_data", o_rx_data, 8'hA5);
    chk("a5_err_cnt", n_err - e0, 0);
    chk("a5_busy_len_ok", (busy_cyc - b0 >= 745) && (busy_cyc - b0 <= 770), 1'b1);
    chk("a5_busy_low", o_rx_busy, 1'b0);

    // Back-to-back frames, no idle gap
    d0 = n_done; e0 = n_err;
    send_frame(8'h00);
    send_frame(8'hFF);
    send_frame(8'h3C);
    wait_ticks(2 * OS);
    chk("b2b_done_cnt", n_done - d0, 3);
    chk("b2b_byte0", rx_log[d0],     8'h00);
    chk("b2b_byte1", rx_log[d0 + 1], 8'hFF);
    chk("b2b_byte2", rx_log[d0 + 2], 8'h3C);
    chk("b2b_err_cnt", n_err - e0, 0);

    // Two-tick low glitch: false start, aborted at mid-bit
    d0 = n_done; e0 = n_err; b0 = busy_cyc;
    #1 rx = 1'b0;
    wait_ticks(2);
    #1 rx = 1'b1;
    wait_ticks(10);
    chk("glitch_busy_len_ok", (busy_cyc - b0 > 0) && (busy_cyc - b0 <= 41), 1'b1);
    chk("glitch_busy_low", o_rx_busy, 1'b0);
    chk("glitch_done_cnt", n_done - d0, 0);
    chk("glitch_err_cnt", n_err - e0, 0);

    // Stop bit low
    d0 = n_done; e0 = n_err;
    send_bad_stop(8'h55);
    chk("ferr_err_cnt", n_err - e0, 1);
    chk("ferr_done_cnt", n_done - d0, 0);
    chk("ferr_data_kept", o_rx_data, 8'h3C);

    // Break: line held low, one frame error per frame time, never done
    d0 = n_done; e0 = n_err;
    #1 rx = 1'b0;
    for (int g = 0; g < 3000 && (n_err - e0) < 3; g++) @(negedge clk);
    rx = 1'b1;
    wait_ticks(2 * OS);
    chk("break_err_cnt", n_err - e0, 3);
    chk("break_done_cnt", n_done - d0, 0);

    // Reset during data bit 4 of 0x81, then 0x7E
    d0 = n_done;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(((i == 0) ? 1'b1 : 1'b0));
    #1 rx = 1'b0;
    wait_ticks(4);
    #1 rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    chk("mrst_data", o_rx_data, 8'h00);
    chk("mrst_done", o_rx_done, 1'b0);
    chk("mrst_busy", o_rx_busy, 1'b0);
    chk("mrst_err",  o_frame_err, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    wait_ticks(2 * OS);
    chk("mrst_idle_busy", o_rx_busy, 1'b0);
    send_frame(8'h7E);
    wait_ticks(2 * OS);
    chk("mrst_done_cnt", n_done - d0, 1);
    chk("mrst_byte", rx_log[d0], 8'h7E);
    chk("mrst_data_out", o_rx_data, 8'h7E);

    // Loopback sweep with a tick on every clk
    tick_always = 1'b1;
    repeat (20) @(posedge clk);
    d0 = n_done; e0 = n_err;
    base = rx_log.size();
    for (int v = 0; v < 256; v++) send_frame(v[7:0]);
    wait_ticks(2 * OS);
    chk("loop_done_cnt", n_done - d0, 256);
    chk("loop_err_cnt", n_err - e0, 0);
    for (int v = 0; v < 256; v++) begin
      if (base + v < rx_log.size())
        chk($sformatf("loop_byte_%0d", v), rx_log[base + v], v[7:0]);
      else
        chk($sformatf("loop_byte_%0d_missing", v), rx_log.size(), base + v + 1);
    end

    chk("done_err_exclusive", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
